// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad door lock controller.
package lock_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ENTRY,
        CHECK,
        UNLOCKED,
        LOCKOUT
    } lock_state_t;

    // Special key codes; 0-9 are digits, 0xC-0xF are ignored.
    localparam logic [3:0] KEY_CLEAR = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;

    // Bit positions inside the 32-bit trigger command word.
    localparam int TRG_ENTRY    = 0;
    localparam int TRG_LOCKOUT  = 1;
    localparam int TRG_ALARM    = 2;
    localparam int TRG_UNLOCK   = 3;
    localparam int TRG_FAIL_LSB = 4;

    function automatic logic is_digit(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

endpackage

// File: rtl/lock_controller_ms_tick.sv
// Free-running divider producing a one-cycle pulse every CLK_HZ/1000 cycles.
module ms_tick #(
    parameter int unsigned CLK_HZ = 50_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int unsigned DIV  = (CLK_HZ / 1000 > 1) ? CLK_HZ / 1000 : 1;
    localparam int          CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    // Divider counter wraps at LAST so the tick spacing is exactly DIV cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/lock_controller.sv
// Keypad door lock sequencer driving the servo stage's 32-bit trigger word.
// Optional build macro LOCK_DOOR_HOLD_EN: keep the door unlocked while it is
// still open after the unlock window, and raise the alarm if it stays open.
module lock_controller
    import lock_pkg::*;
#(
    parameter int unsigned CLK_HZ           = 50_000_000,
    parameter int unsigned CODE_LEN         = 4,
    parameter int unsigned UNLOCK_MS        = 5000,
    parameter int unsigned ENTRY_TIMEOUT_MS = 10000,
    parameter int unsigned MAX_FAILS        = 3,
    parameter int unsigned LOCKOUT_MS       = 30000
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    input  logic [4*CODE_LEN-1:0] passcode,
    input  logic                  door_open,
    output logic [31:0]           trigger,
    output logic                  busy
);

    localparam int         BUF_W     = 4 * CODE_LEN;
    localparam logic [3:0] CODE_LEN4 = 4'(CODE_LEN);
    localparam logic [3:0] MAX_FAIL4 = 4'(MAX_FAILS);

    lock_state_t      state_q, state_d;
    logic [BUF_W-1:0] buf_q, buf_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [3:0]       fail_q, fail_d;
    logic [3:0]       fail_inc;
    logic [31:0]      timer_q, timer_d;
    logic [31:0]      limit;
    logic [31:0]      trigger_q, trigger_d;
    logic             busy_q, busy_d;
    logic             tick, expired, key_digit, hold_alarm_d;
    logic [BUF_W-1:0] key_ext;

`ifdef LOCK_DOOR_HOLD_EN
    logic hold_q, hold_d;
    logic alarm_q, alarm_d;
    assign hold_alarm_d = alarm_d;
`else
    logic unused_door;
    assign unused_door  = door_open;
    assign hold_alarm_d = 1'b0;
`endif

    ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk_i  (CLOCK_50),
        .rst_i  (reset),
        .tick_o (tick)
    );

    assign key_digit = is_digit(key_code);
    assign key_ext   = BUF_W'(key_code);
    assign fail_inc  = (fail_q == 4'hF) ? 4'hF : fail_q + 4'd1;
    // Expiry needs LIMIT+1 ticks after a restart, giving -0/+1 ms resolution.
    assign expired   = tick && (timer_q == limit);

    // Select the ms limit belonging to the timed state we are in.
    always_comb begin
        case (state_q)
            ENTRY:    limit = ENTRY_TIMEOUT_MS;
            UNLOCKED: limit = UNLOCK_MS;
            LOCKOUT:  limit = LOCKOUT_MS;
            default:  limit = '0;
        endcase
    end

    // Next-state logic: key handling, code check, timers and fail counting.
    always_comb begin
        // NOTE: every signal driven here is defaulted first, so no latch is inferred.
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        fail_d  = fail_q;
        timer_d = tick ? timer_q + 32'd1 : timer_q;
`ifdef LOCK_DOOR_HOLD_EN
        hold_d  = hold_q;
        alarm_d = alarm_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (key_valid && key_digit) begin
                    buf_d   = key_ext;
                    cnt_d   = 4'd1;
                    state_d = ENTRY;
                end
            end
            ENTRY: begin
                if (expired) begin
                    // Expiry beats a simultaneous key, which is dropped.
                    state_d = IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                end else if (key_valid) begin
                    if (key_digit) begin
                        timer_d = '0;
                        if (cnt_q < CODE_LEN4) begin
                            buf_d = (buf_q << 4) | key_ext;
                            cnt_d = cnt_q + 4'd1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        state_d = IDLE;
                        buf_d   = '0;
                        cnt_d   = '0;
                        timer_d = '0;
                    end else if (key_code == KEY_ENTER) begin
                        state_d = CHECK;
                        timer_d = '0;
                    end
                end
            end
            CHECK: begin
                buf_d   = '0;
                cnt_d   = '0;
                timer_d = '0;
                if (cnt_q == CODE_LEN4 && buf_q == passcode) begin
                    fail_d  = '0;
                    state_d = UNLOCKED;
                end else begin
                    fail_d  = fail_inc;
                    state_d = (fail_inc == MAX_FAIL4) ? LOCKOUT : IDLE;
                end
            end
            UNLOCKED: begin
`ifdef LOCK_DOOR_HOLD_EN
                if (!hold_q) begin
                    if (expired) begin
                        timer_d = '0;
                        if (door_open) begin
                            hold_d = 1'b1;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end else if (!door_open) begin
                    state_d = IDLE;
                    hold_d  = 1'b0;
                    alarm_d = 1'b0;
                    timer_d = '0;
                end else if (expired) begin
                    // Door held open a further window: alarm until it closes.
                    alarm_d = 1'b1;
                    timer_d = timer_q;
                end
`else
                if (expired) begin
                    state_d = IDLE;
                    timer_d = '0;
                end
`endif
            end
            LOCKOUT: begin
                if (expired) begin
                    fail_d  = '0;
                    state_d = IDLE;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                timer_d = '0;
            end
        endcase
    end

    // Output word derived from next state so the registered copy tracks state_q.
    always_comb begin
        trigger_d                      = '0;
        trigger_d[TRG_ENTRY]           = (state_d == ENTRY);
        trigger_d[TRG_LOCKOUT]         = (state_d == LOCKOUT);
        trigger_d[TRG_ALARM]           = (state_d == LOCKOUT) || hold_alarm_d;
        trigger_d[TRG_UNLOCK]          = (state_d == UNLOCKED);
        trigger_d[TRG_FAIL_LSB +: 4]   = fail_d;
        busy_d                         = (state_d != IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            // NOTE: the digit buffer is reset too, so no partial code survives a reset.
            buf_q     <= '0;
            cnt_q     <= '0;
            fail_q    <= '0;
            timer_q   <= '0;
            trigger_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every register update on the same edge.
            state_q   <= state_d;
            buf_q     <= buf_d;
            cnt_q     <= cnt_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            trigger_q <= trigger_d;
            busy_q    <= busy_d;
        end
    end

`ifdef LOCK_DOOR_HOLD_EN
    // Door-hold phase flags for the unlocked state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            hold_q  <= 1'b0;
            alarm_q <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            alarm_q <= alarm_d;
        end
    end
`endif

    assign trigger = trigger_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_lock_controller.sv
// Directed, scoreboard-checked bench for lock_controller.
module tb_lock_controller;
    import lock_pkg::*;

    localparam int unsigned CLK_HZ           = 4000;
    localparam int unsigned CODE_LEN         = 4;
    localparam int unsigned UNLOCK_MS        = 5;
    localparam int unsigned ENTRY_TIMEOUT_MS = 6;
    localparam int unsigned MAX_FAILS        = 3;
    localparam int unsigned LOCKOUT_MS       = 8;
    localparam int unsigned TICK             = CLK_HZ / 1000;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [15:0] passcode;
    logic        door_open;
    logic [31:0] trigger;
    logic        busy;

    lock_controller #(
        .CLK_HZ           (CLK_HZ),
        .CODE_LEN         (CODE_LEN),
        .UNLOCK_MS        (UNLOCK_MS),
        .ENTRY_TIMEOUT_MS (ENTRY_TIMEOUT_MS),
        .MAX_FAILS        (MAX_FAILS),
        .LOCKOUT_MS       (LOCKOUT_MS)
    ) dut (
        .CLOCK_50  (CLOCK_50),
        .reset     (reset),
        .key_valid (key_valid),
        .key_code  (key_code),
        .passcode  (passcode),
        .door_open (door_open),
        .trigger   (trigger),
        .busy      (busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int unsigned cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [31:0] trig;
        logic        busy;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned t_start;
    logic        in_window;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [31:0] trig, input logic b);
        exp_t e;
        e.tag  = tag;
        e.trig = trig;
        e.busy = b;
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t e;
        e = sb.pop_front();
        check({e.tag, ".trigger"}, trigger, e.trig);
        check({e.tag, ".busy"}, {31'd0, busy}, {31'd0, e.busy});
    endtask

    // One-cycle key strobe, driven from one falling edge to the next.
    task automatic press(input logic [3:0] k);
        key_code  = k;
        key_valid = 1'b1;
        @(negedge CLOCK_50);
        key_valid = 1'b0;
        key_code  = 4'h0;
    endtask

    task automatic enter_digits(input logic [31:0] code, input int n);
        for (int i = 0; i < n; i++) press(code[31-4*i -: 4]);
    endtask

    // Digits then enter: one observation in CHECK, one after it.
    task automatic attempt(input string tag, input logic [31:0] code, input int n,
                           input logic [31:0] check_trig, input logic [31:0] res_trig,
                           input logic res_busy);
        expect_out({tag, "_check"}, check_trig, 1'b1);
        expect_out({tag, "_result"}, res_trig, res_busy);
        enter_digits(code, n);
        press(KEY_ENTER);
        check_out();
        @(negedge CLOCK_50);
        check_out();
    endtask

    task automatic wait_trig(input logic [31:0] want, input int budget);
        int n;
        n = 0;
        while (trigger !== want && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 4'h0;
        passcode  = 16'h1234;
        door_open = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        expect_out("reset", 32'h0, 1'b0);
        check_out();
        reset = 1'b0;
        @(negedge CLOCK_50);
        expect_out("after_release", 32'h0, 1'b0);
        check_out();

        // Correct code unlocks, then relocks on the timer.
        attempt("t1_correct", 32'h1234_0000, 4, 32'h0, 32'h8, 1'b1);
        t_start = cyc;
        expect_out("t1_relock", 32'h0, 1'b0);
        wait_trig(32'h0, 40);
        check_out();
        in_window = (cyc - t_start >= UNLOCK_MS * TICK) && (cyc - t_start <= (UNLOCK_MS + 2) * TICK);
        check("t1_unlock_len", {31'd0, in_window}, 32'd1);

        // Clear after two digits returns to IDLE with no failure.
        expect_out("t3_partial", 32'h1, 1'b1);
        enter_digits(32'h1200_0000, 2);
        check_out();
        expect_out("t3_clear", 32'h0, 1'b0);
        press(KEY_CLEAR);
        check_out();

        // Single digit then idle: still in entry at 5 ms, back to IDLE by 8 ms.
        expect_out("t3_entry_active", 32'h1, 1'b1);
        press(4'd1);
        check_out();
        repeat (19) @(negedge CLOCK_50);
        expect_out("t3_before_timeout", 32'h1, 1'b1);
        check_out();
        repeat (12) @(negedge CLOCK_50);
        expect_out("t3_timeout", 32'h0, 1'b0);
        check_out();

        // Three digits then enter counts as a failure.
        attempt("t3_short", 32'h1230_0000, 3, 32'h0, 32'h10, 1'b0);

        // Fifth digit is ignored; a match also clears the fail count.
        attempt("t4_overlen", 32'h1234_9000, 5, 32'h10, 32'h8, 1'b1);
        expect_out("t4_relock", 32'h0, 1'b0);
        wait_trig(32'h0, 40);
        check_out();
        expect_out("t4_idle_enter", 32'h0, 1'b0);
        press(KEY_ENTER);
        check_out();
        expect_out("t4_idle_clear", 32'h0, 1'b0);
        press(KEY_CLEAR);
        check_out();

        // Three failures lead to lockout with alarm.
        attempt("t2_fail1", 32'h1235_0000, 4, 32'h00, 32'h10, 1'b0);
        attempt("t2_fail2", 32'h1235_0000, 4, 32'h10, 32'h20, 1'b0);
        attempt("t2_fail3", 32'h1235_0000, 4, 32'h20, 32'h36, 1'b1);
        t_start = cyc;
        expect_out("t2_keys_ignored", 32'h36, 1'b1);
        enter_digits(32'h1234_0000, 4);
        press(KEY_ENTER);
        check_out();
        expect_out("t2_lockout_end", 32'h0, 1'b0);
        wait_trig(32'h0, 60);
        check_out();
        in_window = (cyc - t_start >= LOCKOUT_MS * TICK) && (cyc - t_start <= (LOCKOUT_MS + 2) * TICK);
        check("t2_lockout_len", {31'd0, in_window}, 32'd1);

        // Asynchronous reset while unlocked.
        attempt("t5_unlock", 32'h1234_0000, 4, 32'h0, 32'h8, 1'b1);
        repeat (5) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        expect_out("t5_async_unlocked", 32'h0, 1'b0);
        check_out();
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        expect_out("t5_idle_after_unlock", 32'h0, 1'b0);
        check_out();

        // Asynchronous reset while locked out clears the lockout and count.
        attempt("t5_fail1", 32'h9999_0000, 4, 32'h00, 32'h10, 1'b0);
        attempt("t5_fail2", 32'h9999_0000, 4, 32'h10, 32'h20, 1'b0);
        attempt("t5_fail3", 32'h9999_0000, 4, 32'h20, 32'h36, 1'b1);
        repeat (10) @(negedge CLOCK_50);
        #2 reset = 1'b1;
        #1;
        expect_out("t5_async_lockout", 32'h0, 1'b0);
        check_out();
        @(negedge CLOCK_50);
        reset = 1'b0;
        @(negedge CLOCK_50);
        expect_out("t5_idle_after_lockout", 32'h0, 1'b0);
        check_out();
        expect_out("t5_fail_cleared", 32'h1, 1'b1);
        press(4'd7);
        check_out();
        expect_out("t5_clear", 32'h0, 1'b0);
        press(KEY_CLEAR);
        check_out();

`ifdef LOCK_DOOR_HOLD_EN
        // Door held open: unlock held past expiry, then alarm, then relock on close.
        door_open = 1'b1;
        attempt("t6_unlock", 32'h1234_0000, 4, 32'h0, 32'h8, 1'b1);
        repeat (30) @(negedge CLOCK_50);
        expect_out("t6_held", 32'h8, 1'b1);
        check_out();
        expect_out("t6_alarm", 32'hC, 1'b1);
        wait_trig(32'hC, 40);
        check_out();
        door_open = 1'b0;
        @(negedge CLOCK_50);
        expect_out("t6_closed", 32'h0, 1'b0);
        check_out();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
